// File: rtl/ahb_slave_arbiter_gen_pkg.sv
// Shared types for the generated per-slave AHB arbiters.
package ahb_slave_arbiter_gen_pkg;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    RR    = 2'd1,
    DYN   = 2'd2
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Beat limit of a burst; undefined-length INCR uses max_incr (0 = unlimited).
  function automatic int unsigned burst_beats(hburst_type hb, int unsigned max_incr);
    int unsigned beats;
    beats = 1;
    case (hb)
      SINGLE:         beats = 1;
      INCR:           beats = max_incr;
      WRAP4, INCR4:   beats = 4;
      WRAP8, INCR8:   beats = 8;
      WRAP16, INCR16: beats = 16;
      default:        beats = 1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_gen_select.sv
// Combinational winner selector: fixed, round-robin or dynamic priority.
module ahb_arb_select
  import ahb_slave_arbiter_gen_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned PRIOR_BIT  = 2,
  parameter int unsigned ARB_MODE   = 0,
  localparam int unsigned IW        = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0]           hreq,
  input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
  input  logic [IW-1:0]                   rr_ptr,
  output logic [IW-1:0]                   winner,
  output logic                            valid
);

  always_comb begin
    int unsigned idx;
    logic [PRIOR_BIT-1:0] best;
    idx    = 0;
    best   = '0;
    winner = '0;
    valid  = 1'b0;
    case (arb_mode_e'(ARB_MODE))
      RR: begin
        for (int unsigned k = 1; k <= MASTER_NUM; k++) begin
          idx = int'(rr_ptr) + k;
          if (idx >= MASTER_NUM) idx = idx - MASTER_NUM;
          if (!valid && hreq[idx]) begin
            valid  = 1'b1;
            winner = IW'(idx);
          end
        end
      end
      DYN: begin
        // Strict '>' keeps the lower index on equal priority.
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
          if (hreq[i] && (!valid || hprior[i*PRIOR_BIT +: PRIOR_BIT] > best)) begin
            valid  = 1'b1;
            winner = IW'(i);
            best   = hprior[i*PRIOR_BIT +: PRIOR_BIT];
          end
        end
      end
      default: begin
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
          if (!valid && hreq[i]) begin
            valid  = 1'b1;
            winner = IW'(i);
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/ahb_slave_arbiter_gen.sv
// Per-slave AHB arbiter; hands the slave over only at burst boundaries.
module ahb_slave_arbiter_gen
  import ahb_slave_arbiter_gen_pkg::*;
#(
  parameter int unsigned MASTER_NUM     = 4,
  parameter int unsigned PRIOR_BIT      = 2,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned MAX_INCR_BEATS = 16,
  localparam int unsigned IW            = $clog2(MASTER_NUM)
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  input  logic [MASTER_NUM-1:0]           hreq,
  input  logic [MASTER_NUM-1:0]           hlock,
  input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
  input  logic [1:0]                      htrans,
  input  hburst_type                      hburst,
  input  logic                            hwait,
  output logic [MASTER_NUM-1:0]           hgrant,
  output logic                            hsel,
  output logic [IW-1:0]                   hmaster,
  output logic                            hmastlock,
  output logic                            hlast
);

  localparam int unsigned CW = $clog2((MAX_INCR_BEATS > 16) ? MAX_INCR_BEATS : 16) + 1;

  arb_state_e            state;
  logic [MASTER_NUM-1:0] grant;
  logic [CW-1:0]         count;
  hburst_type            burst_q;
  logic [IW-1:0]         rr_ptr;

  logic [IW-1:0]         sel_ptr;
  logic [IW-1:0]         win_idx;
  logic                  win_vld;
  logic [MASTER_NUM-1:0] win_oh;
  logic                  is_nseq;
  logic                  is_beat;
  logic                  acc;
  logic                  ho;
  int unsigned           limit;
  int unsigned           beat_idx;

  // While owned, the selector searches after the current owner so a handover
  // never re-picks it ahead of waiting masters; rr_ptr only matters from IDLE.
  assign sel_ptr = (state == ST_OWN) ? hmaster : rr_ptr;

  ahb_arb_select #(
    .MASTER_NUM (MASTER_NUM),
    .PRIOR_BIT  (PRIOR_BIT),
    .ARB_MODE   (ARB_MODE)
  ) u_select (
    .hreq   (hreq),
    .hprior (hprior),
    .rr_ptr (sel_ptr),
    .winner (win_idx),
    .valid  (win_vld)
  );

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  assign is_nseq  = (htrans == HTRANS_NONSEQ);
  assign is_beat  = is_nseq || (htrans == HTRANS_SEQ);
  assign acc      = is_beat && !hwait;
  assign limit    = burst_beats(is_nseq ? hburst : burst_q, MAX_INCR_BEATS);
  assign beat_idx = is_nseq ? 32'd1 : (32'(count) + 32'd1);
  assign hlast    = (state == ST_OWN) && is_beat && (limit != 0) && (beat_idx == limit);

  assign ho = !hwait && (state == ST_OWN) &&
              ((acc && hlast) || ((htrans == HTRANS_IDLE) && !hreq[hmaster]));

  assign hgrant = grant & ~{MASTER_NUM{hwait}};
  assign hsel   = |grant;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      count     <= '0;
      burst_q   <= SINGLE;
      rr_ptr    <= IW'(MASTER_NUM - 1);
      hmaster   <= '0;
      hmastlock <= 1'b0;
    end else if (!hwait) begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            grant     <= win_oh;
            hmaster   <= win_idx;
            hmastlock <= hlock[win_idx];
            state     <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (acc) begin
            if (is_nseq) begin
              burst_q <= hburst;
              count   <= CW'(1);
            end else begin
              count <= count + 1'b1;
            end
          end
          if (ho) begin
            count <= '0;
            if (hlock[hmaster]) begin
              hmastlock <= 1'b1;
            end else if (win_vld) begin
              grant     <= win_oh;
              hmaster   <= win_idx;
              hmastlock <= hlock[win_idx];
              if (arb_mode_e'(ARB_MODE) == RR) rr_ptr <= hmaster;
            end else begin
              grant     <= '0;
              hmastlock <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter_gen.sv
// Directed bench: fixed, round-robin, dynamic and INCR-limited arbiter instances on shared stimulus.
module tb_ahb_slave_arbiter_gen;
  import ahb_slave_arbiter_gen_pkg::*;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hreq;
  logic [3:0] hlock;
  logic [7:0] hprior;
  logic [1:0] htrans;
  hburst_type hburst;
  logic       hwait;

  logic [3:0] hgrant_f, hgrant_r, hgrant_d, hgrant_l;
  logic       hsel_f, hsel_r, hsel_d, hsel_l;
  logic [1:0] hmaster_f, hmaster_r, hmaster_d, hmaster_l;
  logic       hmastlock_f, hmastlock_r, hmastlock_d, hmastlock_l;
  logic       hlast_f, hlast_r, hlast_d, hlast_l;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 hclk = ~hclk;

  ahb_slave_arbiter_gen #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(0), .MAX_INCR_BEATS(16)) u_fix (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .hprior(hprior),
    .htrans(htrans), .hburst(hburst), .hwait(hwait), .hgrant(hgrant_f), .hsel(hsel_f),
    .hmaster(hmaster_f), .hmastlock(hmastlock_f), .hlast(hlast_f));

  ahb_slave_arbiter_gen #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(1), .MAX_INCR_BEATS(16)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .hprior(hprior),
    .htrans(htrans), .hburst(hburst), .hwait(hwait), .hgrant(hgrant_r), .hsel(hsel_r),
    .hmaster(hmaster_r), .hmastlock(hmastlock_r), .hlast(hlast_r));

  ahb_slave_arbiter_gen #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(2), .MAX_INCR_BEATS(16)) u_dyn (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .hprior(hprior),
    .htrans(htrans), .hburst(hburst), .hwait(hwait), .hgrant(hgrant_d), .hsel(hsel_d),
    .hmaster(hmaster_d), .hmastlock(hmastlock_d), .hlast(hlast_d));

  ahb_slave_arbiter_gen #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(0), .MAX_INCR_BEATS(4)) u_lim (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock), .hprior(hprior),
    .htrans(htrans), .hburst(hburst), .hwait(hwait), .hgrant(hgrant_l), .hsel(hsel_l),
    .hmaster(hmaster_l), .hmastlock(hmastlock_l), .hlast(hlast_l));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    hreset_n = 1'b0;
    hreq     = '0;
    hlock    = '0;
    hprior   = '0;
    htrans   = HTRANS_IDLE;
    hburst   = SINGLE;
    hwait    = 1'b0;
    step();
    step();
    hreset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fixed priority
    do_reset();
    settle();
    check("rst_hsel", 32'(hsel_f), 32'd0);
    check("rst_hgrant", 32'(hgrant_f), 32'd0);
    check("rst_hmaster", 32'(hmaster_f), 32'd0);
    check("rst_hmastlock", 32'(hmastlock_f), 32'd0);
    check("rst_hlast", 32'(hlast_f), 32'd0);
    hreq = 4'b1010;
    settle();
    check("fix_pre_grant_hsel", 32'(hsel_f), 32'd0);
    step();
    check("fix_grant", 32'(hgrant_f), 32'b0010);
    check("fix_hmaster", 32'(hmaster_f), 32'd1);
    check("fix_hsel", 32'(hsel_f), 32'd1);
    htrans = HTRANS_NONSEQ;
    hburst = SINGLE;
    hreq   = 4'b1000;
    settle();
    check("fix_single_hlast", 32'(hlast_f), 32'd1);
    step();
    check("fix_moved_grant", 32'(hgrant_f), 32'b1000);
    check("fix_moved_hmaster", 32'(hmaster_f), 32'd3);
    htrans = HTRANS_IDLE;
    hreq   = 4'b0000;
    step();
    check("fix_release_hsel", 32'(hsel_f), 32'd0);

    // Round-robin
    do_reset();
    hreq = 4'b1111;
    step();
    check("rr_first_hmaster", 32'(hmaster_r), 32'd0);
    check("rr_first_grant", 32'(hgrant_r), 32'b0001);
    for (int i = 0; i < 4; i++) begin
      htrans = HTRANS_NONSEQ;
      hburst = SINGLE;
      settle();
      check("rr_single_hlast", 32'(hlast_r), 32'd1);
      step();
      check("rr_next_hmaster", 32'(hmaster_r), 32'((i + 1) % 4));
    end
    htrans = HTRANS_IDLE;

    // Dynamic priority: masters 3..0 = 3,1,3,0
    do_reset();
    hprior = {2'd3, 2'd1, 2'd3, 2'd0};
    hreq   = 4'b1111;
    step();
    check("dyn_hmaster", 32'(hmaster_d), 32'd1);
    check("dyn_grant", 32'(hgrant_d), 32'b0010);
    htrans = HTRANS_NONSEQ;
    hburst = INCR4;
    settle();
    check("dyn_b1_hlast", 32'(hlast_d), 32'd0);
    step();
    hprior = {2'd3, 2'd1, 2'd0, 2'd0};
    htrans = HTRANS_SEQ;
    for (int b = 2; b <= 4; b++) begin
      settle();
      check("dyn_mid_hmaster", 32'(hmaster_d), 32'd1);
      check("dyn_hlast", 32'(hlast_d), (b == 4) ? 32'd1 : 32'd0);
      step();
    end
    check("dyn_after_hmaster", 32'(hmaster_d), 32'd3);
    check("dyn_after_grant", 32'(hgrant_d), 32'b1000);
    htrans = HTRANS_IDLE;

    // INCR8 with a 3-cycle wait on beat 5
    do_reset();
    hreq = 4'b0011;
    step();
    check("w_hmaster0", 32'(hmaster_f), 32'd0);
    htrans = HTRANS_NONSEQ;
    hburst = INCR8;
    step();
    htrans = HTRANS_SEQ;
    for (int b = 2; b <= 4; b++) step();
    hreq  = 4'b0010;
    hwait = 1'b1;
    for (int w = 0; w < 3; w++) begin
      settle();
      check("w_stall_hgrant", 32'(hgrant_f), 32'd0);
      check("w_stall_hsel", 32'(hsel_f), 32'd1);
      check("w_stall_hlast", 32'(hlast_f), 32'd0);
      step();
    end
    hwait = 1'b0;
    for (int b = 5; b <= 8; b++) begin
      settle();
      check("w_hgrant", 32'(hgrant_f), 32'b0001);
      check("w_hlast", 32'(hlast_f), (b == 8) ? 32'd1 : 32'd0);
      step();
    end
    check("w_ho_hmaster", 32'(hmaster_f), 32'd1);
    htrans = HTRANS_IDLE;

    // Undefined INCR capped at 4 beats
    do_reset();
    hreq = 4'b0101;
    step();
    htrans = HTRANS_NONSEQ;
    hburst = INCR;
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) hreq = 4'b0100;
      settle();
      check("lim_hlast", 32'(hlast_l), (b == 4) ? 32'd1 : 32'd0);
      step();
      htrans = HTRANS_SEQ;
    end
    check("lim_ho_hmaster", 32'(hmaster_l), 32'd2);
    check("lim_ho_grant", 32'(hgrant_l), 32'b0100);

    // Same with master 0 locked
    do_reset();
    hreq  = 4'b0101;
    hlock = 4'b0001;
    step();
    check("lock_hmastlock", 32'(hmastlock_l), 32'd1);
    htrans = HTRANS_NONSEQ;
    hburst = INCR;
    for (int b = 1; b <= 4; b++) begin
      settle();
      check("lock_hlast", 32'(hlast_l), (b == 4) ? 32'd1 : 32'd0);
      step();
      htrans = HTRANS_SEQ;
    end
    check("lock_keep_grant", 32'(hgrant_l), 32'b0001);
    check("lock_keep_hmastlock", 32'(hmastlock_l), 32'd1);
    htrans = HTRANS_IDLE;

    // Reset during beat 3 of WRAP16
    do_reset();
    hreq = 4'b0001;
    step();
    htrans = HTRANS_NONSEQ;
    hburst = WRAP16;
    step();
    htrans = HTRANS_SEQ;
    step();
    settle();
    check("rw_b3_hgrant", 32'(hgrant_f), 32'b0001);
    hreset_n = 1'b0;
    settle();
    check("rw_async_hgrant", 32'(hgrant_f), 32'd0);
    check("rw_async_hsel", 32'(hsel_f), 32'd0);
    @(negedge hclk);
    hreset_n = 1'b1;
    htrans   = HTRANS_IDLE;
    hreq     = 4'b0100;
    step();
    check("rw_rearb_hmaster", 32'(hmaster_f), 32'd2);
    check("rw_rearb_grant", 32'(hgrant_f), 32'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
